// File: rtl/qam_pkg.sv
// Shared constants and types for the QAM receive path.
//   SAMPLE_W            : serial frame length / sample width (signed)
//   SAMPLES_PER_SYMBOL  : good samples integrated into one symbol decision
//   ACC_W_DEF           : default integrator width
//   SYM_BIT_I/SYM_BIT_Q : symbol bit carrying the cos / sin arm polarity (1 = negative)
//   state_e             : symbol integrator states
package qam_pkg;
  localparam int SAMPLE_W           = 8;
  localparam int SAMPLES_PER_SYMBOL = 125;
  localparam int ACC_W_DEF          = 24;

  localparam int SYM_BIT_I = 1;  // cos-arm polarity
  localparam int SYM_BIT_Q = 0;  // sin-arm polarity

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DECIDE
  } state_e;
endpackage

// File: rtl/qam_serial_deser.sv
// LSB-first serial-to-parallel converter with frame checking.
//   clk, rst             : clock, synchronous active-high reset
//   data_bit_in          : serial bit, one per clk
//   data_in_complete_bit : frame strobe, expected on the clk carrying bit W-1
//   word_done            : combinational, a well-formed frame completes this clk
//   sample_out           : last assembled word (held)
//   sample_valid         : one-clk strobe, clk after word_done
//   frame_err            : one-clk strobe for an early strobe or a missing strobe
module qam_serial_deser
  import qam_pkg::*;
#(
  parameter int W = SAMPLE_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         data_bit_in,
  input  logic         data_in_complete_bit,
  output logic         word_done,
  output logic [W-1:0] sample_out,
  output logic         sample_valid,
  output logic         frame_err
);
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  logic [CW-1:0] bit_cnt;
  logic [W-1:0]  shreg, word;
  logic          at_last;

  // Word as it will look once this clk's bit lands.
  always_comb begin
    word          = shreg;
    word[bit_cnt] = data_bit_in;
  end

  assign at_last   = (bit_cnt == LAST);
  assign word_done = data_in_complete_bit && at_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt      <= '0;
      shreg        <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      shreg        <= word;
      sample_valid <= word_done;
      // Strobe without last bit, or last bit without strobe: both malformed.
      frame_err    <= data_in_complete_bit ^ at_last;
      if (word_done) sample_out <= word;
      bit_cnt <= (data_in_complete_bit || at_last) ? '0 : bit_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/qam_demod_rx.sv
// QAM receiver: deserializes samples, correlates against sin/cos references,
// integrates over a symbol and decides the 2-bit symbol.
//   clk, rst             : clock, synchronous active-high reset
//   data_bit_in          : serial sample bit, LSB first
//   data_in_complete_bit : frame-complete strobe
//   sym_start            : symbol alignment pulse (starts / realigns integration)
//   sin_ref, cos_ref     : signed references, captured when a frame completes
//   sample_out/_valid    : assembled sample and its strobe
//   symbol_out/_valid    : decided symbol and its strobe
//   frame_err            : malformed-frame strobe
module qam_demod_rx #(
  parameter int SAMPLE_W           = qam_pkg::SAMPLE_W,
  parameter int SAMPLES_PER_SYMBOL = qam_pkg::SAMPLES_PER_SYMBOL,
  parameter int ACC_W              = qam_pkg::ACC_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                data_bit_in,
  input  logic                data_in_complete_bit,
  input  logic                sym_start,
  input  logic [SAMPLE_W-1:0] sin_ref,
  input  logic [SAMPLE_W-1:0] cos_ref,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_valid,
  output logic [1:0]          symbol_out,
  output logic                symbol_valid,
  output logic                frame_err
);
  localparam int PW     = 2 * SAMPLE_W;
  localparam int STAGES = 2;
  localparam int CNT_W  = $clog2(SAMPLES_PER_SYMBOL + 1);
  localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(SAMPLES_PER_SYMBOL - 1);

  logic                       word_done;
  logic signed [SAMPLE_W-1:0] samp_s, sin_r, cos_r;
  logic signed [PW-1:0]       p_i, p_q;
  logic signed [ACC_W-1:0]    acc_i, acc_q, ext_i, ext_q;
  logic [CNT_W-1:0]           cnt;
  logic [STAGES:1]            vld_pipe;  // [1] sample held, [2] products held
  logic [1:0]                 decision;
  qam_pkg::state_e            state, state_nxt;

  qam_serial_deser #(.W(SAMPLE_W)) u_deser (
    .clk                 (clk),
    .rst                 (rst),
    .data_bit_in         (data_bit_in),
    .data_in_complete_bit(data_in_complete_bit),
    .word_done           (word_done),
    .sample_out          (sample_out),
    .sample_valid        (sample_valid),
    .frame_err           (frame_err)
  );

  assign samp_s = sample_out;
  assign ext_i  = {{(ACC_W-PW){p_i[PW-1]}}, p_i};
  assign ext_q  = {{(ACC_W-PW){p_q[PW-1]}}, p_q};

  always_comb begin
    decision                     = '0;
    decision[qam_pkg::SYM_BIT_I] = acc_i[ACC_W-1];
    decision[qam_pkg::SYM_BIT_Q] = acc_q[ACC_W-1];
  end

  // Reference capture and correlation products.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      sin_r    <= '0;
      cos_r    <= '0;
      p_i      <= '0;
      p_q      <= '0;
    end else begin
      vld_pipe <= {vld_pipe[1], word_done};
      if (word_done) begin
        sin_r <= sin_ref;
        cos_r <= cos_ref;
      end
      p_i <= samp_s * cos_r;
      p_q <= samp_s * sin_r;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      qam_pkg::ST_IDLE:   if (sym_start) state_nxt = qam_pkg::ST_ACCUM;
      qam_pkg::ST_ACCUM:
        if (sym_start) state_nxt = qam_pkg::ST_ACCUM;
        else if (vld_pipe[2] && cnt == CNT_PENULT) state_nxt = qam_pkg::ST_DECIDE;
      qam_pkg::ST_DECIDE: state_nxt = qam_pkg::ST_ACCUM;
      default:            state_nxt = qam_pkg::ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= qam_pkg::ST_IDLE;
      acc_i        <= '0;
      acc_q        <= '0;
      cnt          <= '0;
      symbol_out   <= '0;
      symbol_valid <= 1'b0;
    end else begin
      state        <= state_nxt;
      symbol_valid <= 1'b0;
      if (sym_start) begin
        // Restart integration; a product landing now is the first sample.
        acc_i <= vld_pipe[2] ? ext_i : '0;
        acc_q <= vld_pipe[2] ? ext_q : '0;
        cnt   <= vld_pipe[2] ? CNT_W'(1) : '0;
      end else begin
        case (state)
          qam_pkg::ST_ACCUM:
            if (vld_pipe[2]) begin
              acc_i <= acc_i + ext_i;
              acc_q <= acc_q + ext_q;
              cnt   <= cnt + 1'b1;
            end
          qam_pkg::ST_DECIDE: begin
            symbol_out   <= decision;
            symbol_valid <= 1'b1;
            acc_i        <= vld_pipe[2] ? ext_i : '0;
            acc_q        <= vld_pipe[2] ? ext_q : '0;
            cnt          <= vld_pipe[2] ? CNT_W'(1) : '0;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_qam_demod_rx.sv
// Directed bench for qam_demod_rx: framing, correlation decisions, realign and reset.
module tb_qam_demod_rx;
  logic       clk = 1'b0, rst = 1'b1;
  logic       data_bit_in = 1'b0, data_in_complete_bit = 1'b0, sym_start = 1'b0;
  logic [7:0] sin_ref = '0, cos_ref = '0;
  logic [7:0] sample_out;
  logic       sample_valid, symbol_valid, frame_err;
  logic [1:0] symbol_out;

  qam_demod_rx dut (
    .clk                 (clk),
    .rst                 (rst),
    .data_bit_in         (data_bit_in),
    .data_in_complete_bit(data_in_complete_bit),
    .sym_start           (sym_start),
    .sin_ref             (sin_ref),
    .cos_ref             (cos_ref),
    .sample_out          (sample_out),
    .sample_valid        (sample_valid),
    .symbol_out          (symbol_out),
    .symbol_valid        (symbol_valid),
    .frame_err           (frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0;
  int sv_cnt = 0, sv_cyc = 0, last_strobe = 0, s_end = 0;
  logic [1:0] sv_val = '0;
  logic       last_sv = 1'b0, last_fe = 1'b0;
  logic [7:0] last_so = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (symbol_valid) begin
      sv_cnt++;
      sv_cyc = cyc;
      sv_val = symbol_out;
    end
  endtask

  // nbits bits of w, strobe on the last one if strb, sym_start on bit 3 if ss.
  task automatic send_frame(input logic [7:0] w, input int nbits, input bit strb, input bit ss);
    for (int i = 0; i < nbits; i++) begin
      data_bit_in          = w[i];
      data_in_complete_bit = strb && (i == nbits - 1);
      sym_start            = ss && (i == 3);
      step();
      if (i == nbits - 1) begin
        if (strb) last_strobe = cyc;
        last_sv = sample_valid;
        last_fe = frame_err;
        last_so = sample_out;
      end
    end
    data_in_complete_bit = 1'b0;
    sym_start            = 1'b0;
  endtask

  task automatic send_n(input logic [7:0] w, input int n, input bit ss_first);
    for (int k = 0; k < n; k++) send_frame(w, 8, 1'b1, ss_first && (k == 0));
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_sample_out"}, 32'(sample_out), 32'd0);
    chk({pfx, "_sample_valid"}, 32'(sample_valid), 32'd0);
    chk({pfx, "_symbol_out"}, 32'(symbol_out), 32'd0);
    chk({pfx, "_symbol_valid"}, 32'(symbol_valid), 32'd0);
    chk({pfx, "_frame_err"}, 32'(frame_err), 32'd0);
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    step(); step(); step();
    chk_zero("rst");
    rst = 1'b0;

    // Good frame 0x5A
    send_frame(8'h5A, 8, 1'b1, 1'b0);
    chk("f5a_valid", 32'(last_sv), 32'd1);
    chk("f5a_data", 32'(last_so), 32'h5A);
    chk("f5a_err", 32'(last_fe), 32'd0);

    // Early strobe on 5th bit
    send_frame(8'hFF, 5, 1'b1, 1'b0);
    chk("early_err", 32'(last_fe), 32'd1);
    chk("early_valid", 32'(last_sv), 32'd0);
    chk("early_hold", 32'(last_so), 32'h5A);

    // Recovery frame 0x81
    send_frame(8'h81, 8, 1'b1, 1'b0);
    chk("f81_valid", 32'(last_sv), 32'd1);
    chk("f81_data", 32'(last_so), 32'h81);
    chk("f81_err", 32'(last_fe), 32'd0);

    // Eight bits with no strobe
    send_frame(8'h33, 8, 1'b0, 1'b0);
    chk("nostb_err", 32'(last_fe), 32'd1);
    chk("nostb_valid", 32'(last_sv), 32'd0);
    chk("idle_no_symbol", 32'(sv_cnt), 32'd0);

    // Symbol: +100 * cos(+100), sin 0 -> 00
    cos_ref = 8'd100; sin_ref = 8'd0; sv_cnt = 0;
    send_n(8'd100, 125, 1'b1);
    s_end = last_strobe;
    send_frame(8'h00, 8, 1'b1, 1'b0);
    chk("sym00_count", 32'(sv_cnt), 32'd1);
    chk("sym00_latency", 32'(sv_cyc - s_end), 32'd3);
    chk("sym00_value", 32'(sv_val), 32'd0);

    // Symbol: -100 with cos=sin=+100 -> 11
    cos_ref = 8'd100; sin_ref = 8'd100; sv_cnt = 0;
    send_n(8'h9C, 125, 1'b1);
    s_end = last_strobe;
    send_frame(8'h00, 8, 1'b1, 1'b0);
    chk("sym11_count", 32'(sv_cnt), 32'd1);
    chk("sym11_latency", 32'(sv_cyc - s_end), 32'd3);
    chk("sym11_value", 32'(sv_val), 32'd3);

    // Realign after 60 large positive samples; a small negative symbol follows
    sv_cnt = 0;
    send_n(8'd100, 60, 1'b1);
    chk("partial_no_symbol", 32'(sv_cnt), 32'd0);
    send_n(8'hF6, 125, 1'b1);
    s_end = last_strobe;
    send_frame(8'h00, 8, 1'b1, 1'b0);
    chk("realign_count", 32'(sv_cnt), 32'd1);
    chk("realign_latency", 32'(sv_cyc - s_end), 32'd3);
    chk("realign_value", 32'(sv_val), 32'd3);

    // Reset mid-symbol and mid-frame
    send_n(8'hF6, 40, 1'b1);
    send_frame(8'h00, 3, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    chk_zero("midrst");
    rst = 1'b0;
    sv_cnt = 0;
    send_n(8'hF6, 125, 1'b0);
    send_frame(8'h00, 8, 1'b1, 1'b0);
    chk("postrst_idle", 32'(sv_cnt), 32'd0);
    send_n(8'hF6, 125, 1'b1);
    s_end = last_strobe;
    send_frame(8'h00, 8, 1'b1, 1'b0);
    chk("postrst_count", 32'(sv_cnt), 32'd1);
    chk("postrst_latency", 32'(sv_cyc - s_end), 32'd3);
    chk("postrst_value", 32'(sv_val), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/qam_demod_rx.md
Name: qam_demod_rx

Overview:
- Receive end of the QAM serial link.
- Deserializes the LSB-first bit stream and its frame-complete strobe into signed 8-bit samples.
- Correlates each sample against the local sin/cos reference and integrates over one symbol period.
- Decides the transmitted 2-bit symbol; sits between the serial line input and the downstream data sink.

Parameters:
- SAMPLE_W, 8, bits per serial frame / sample width (signed two's complement)
- SAMPLES_PER_SYMBOL, 125, samples integrated per symbol (1000 clk symbol / 8 clk frame)
- ACC_W, 24, accumulator width; must be ≥ 2*SAMPLE_W + clog2(SAMPLES_PER_SYMBOL)

Ports:
- clk, input, 1, system clock; all logic on posedge
- rst, input, 1, synchronous active-high reset
- data_bit_in, input, 1, serial sample bit, LSB first, one bit per clk
- data_in_complete_bit, input, 1, high on the clk carrying bit SAMPLE_W-1 of a frame
- sym_start, input, 1, one-clk pulse marking the first sample of a symbol
- sin_ref, input, 8, signed sine reference, valid on every clk
- cos_ref, input, 8, signed cosine reference, valid on every clk
- sample_out, output, 8, last assembled sample
- sample_valid, output, 1, one-clk strobe for sample_out
- symbol_out, output, 2, decided symbol
- symbol_valid, output, 1, one-clk strobe for symbol_out
- frame_err, output, 1, one-clk strobe when a frame is malformed

Behaviour:
- Reset values: all outputs 0; bit counter 0; shift register 0; both accumulators 0; state IDLE.
- Deserializer:
  - On each clk, data_bit_in is written to shift position bit_cnt, then bit_cnt increments.
  - When data_in_complete_bit=1 and bit_cnt==SAMPLE_W-1: the word is complete; next clk sample_out=word and sample_valid=1; bit_cnt→0.
- Framing error:
  - Strobe seen with bit_cnt≠SAMPLE_W-1: frame_err=1 next clk, word discarded, bit_cnt→0, no sample_valid.
  - bit_cnt reaching SAMPLE_W-1 without the strobe: bit_cnt wraps to 0, frame_err=1, word discarded.
- Reference capture: sin_ref/cos_ref are registered on the same clk the frame completes and paired with that sample.
- Pipeline:
  - S1: sample_valid.
  - S2: registered products p_i=sample*cos, p_q=sample*sin (signed 16 bit).
  - S3: sign-extend to ACC_W and add into acc_i/acc_q.
- FSM:
  - IDLE: ignore samples; sym_start→ACCUM, counter cleared.
  - ACCUM: accumulate each S3 product and count samples. When count reaches SAMPLES_PER_SYMBOL→DECIDE.
  - DECIDE (one clk):
    - symbol_out[1]=acc_i<0; symbol_out[0]=acc_q<0; symbol_valid=1.
    - Clear accumulators and count; →ACCUM (free-running after first sym_start).
- Latency: symbol_valid asserts 3 clk after the clk carrying the final frame's complete strobe.
- sym_start in ACCUM/DECIDE: realign. Partial accumulation is discarded with no symbol_valid; the sample in flight when sym_start arrives is counted as the new symbol's first sample.
- frame_err does not advance the sample count; the symbol is still decided after SAMPLES_PER_SYMBOL good samples.
- Arithmetic: two's complement throughout, no saturation. ACC_W sizing guarantees no overflow.
- Reset mid-frame/mid-symbol: everything returns to reset values the next clk; any in-flight products are dropped.

Decomposition:
- Shared package qam_pkg:
  - SAMPLE_W, SAMPLES_PER_SYMBOL
  - symbol bit mapping constants (bit1↔cos polarity, bit0↔sin polarity; 1=negative)
  - FSM state enum
- One natural sub-module: qam_serial_deser (shift register, bit counter, frame check, sample_valid/frame_err).

Test Plan:
- Serial 0x5A LSB-first with strobe on bit 7 → sample_out=0x5A, sample_valid one clk after strobe; no frame_err.
- Strobe on 5th bit → frame_err pulse, no sample_valid; next well-formed 0x81 frame → sample_out=0x81.
- sym_start, then 125 frames of +cos_ref with sin_ref=0 (cos_ref=+100, sample=+100) → symbol_out=2'b00, symbol_valid 3 clk after last strobe.
- 125 frames sample=-100 with cos_ref=+100, sin_ref=+100 → symbol_out=2'b11.
- Second sym_start after 60 samples → no symbol_valid for the partial symbol; decision after the next 125 samples.
- rst asserted mid-symbol after 40 samples → all outputs 0; no symbol_valid until a new sym_start plus 125 samples.
